// File: rtl/round_robin_index_arbiter_8.sv
// Eight-requester round-robin arbiter with binary-index grant output, grant hold,
// release handshake and a hold-timeout that forces rotation to the next requester.
module round_robin_index_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       Clock_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [7:0] Request_In,
  input  logic       Release_In,
  output logic       Grant_Valid_Out,
  output logic [2:0] Grant_Index_Out,
  output logic       Timeout_Out
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

  state_e     state_q, state_d;
  logic [2:0] index_q, index_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] hold_q, hold_d;
  logic       timeout_q, timeout_d;

  logic [2:0] pick;
  logic       pick_found;
  logic [2:0] cand;

  // First requester at or above the pointer, wrapping 7 -> 0.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!pick_found && Request_In[cand]) begin
        pick       = cand;
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (Enable_In && pick_found) begin
          index_d = pick;
          hold_d  = 8'd1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Release/withdraw/disable outrank the timeout, so no pulse on a tie.
        if (!Enable_In || Release_In || !Request_In[index_q]) begin
          state_d = IDLE;
          ptr_d   = index_q + 3'd1;
          hold_d  = '0;
        end else if (hold_q == HOLD_LIMIT) begin
          state_d   = IDLE;
          ptr_d     = index_q + 3'd1;
          hold_d    = '0;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q   <= IDLE;
      index_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign Grant_Valid_Out = (state_q == GRANT);
  assign Grant_Index_Out = index_q;
  assign Timeout_Out     = timeout_q;

endmodule
